// File: rtl/core_sequencer.sv
// core_sequencer: RV32I control decode plus run/halt/step/trap/skip sequencer.
// Define CORE_SEQ_INSTRET_EN to build the retired-instruction counter; otherwise instret is tied to 0.

module core_sequencer #(
  parameter int BOOT_HALTED = 0,
  parameter int INSTRET_W   = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          Instr,
  input  logic [31:0]          ALUResults,
  input  logic                 dbg_halt_req,
  input  logic                 dbg_run_req,
  input  logic                 dbg_step_req,
  output logic                 regWE,
  output logic                 rs1sel,
  output logic                 rs2sel,
  output logic [1:0]           regsel,
  output logic [1:0]           PCsel,
  output logic [2:0]           ImmSel,
  output logic [3:0]           ALUControl,
  output logic                 we,
  output logic [2:0]           mode,
  output logic                 halted,
  output logic                 trap,
  output logic [1:0]           trap_cause,
  output logic [INSTRET_W-1:0] instret
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_SLL   = 4'b0010;
  localparam logic [3:0] ALU_SLT   = 4'b0011;
  localparam logic [3:0] ALU_SLTU  = 4'b0100;
  localparam logic [3:0] ALU_XOR   = 4'b0101;
  localparam logic [3:0] ALU_SRL   = 4'b0110;
  localparam logic [3:0] ALU_SRA   = 4'b0111;
  localparam logic [3:0] ALU_OR    = 4'b1000;
  localparam logic [3:0] ALU_AND   = 4'b1001;
  localparam logic [3:0] ALU_PASSB = 4'b1010;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  localparam logic [1:0] PC_PLUS4 = 2'b00;
  localparam logic [1:0] PC_IMM   = 2'b01;
  localparam logic [1:0] PC_ALU   = 2'b10;
  localparam logic [1:0] PC_HOLD  = 2'b11;

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_DMEM = 2'b01;
  localparam logic [1:0] WB_PC4  = 2'b10;

  typedef enum logic [2:0] {
    ST_RUN  = 3'd0,
    ST_HALT = 3'd1,
    ST_STEP = 3'd2,
    ST_TRAP = 3'd3,
    ST_SKIP = 3'd4
  } state_t;

  localparam state_t ST_BOOT = (BOOT_HALTED != 0) ? ST_HALT : ST_RUN;

  state_t     r_state;
  logic       r_skip_to_run;
  logic [1:0] r_trap_cause;

  logic [6:0] w_op;
  logic [2:0] w_f3;
  logic [6:0] w_f7;
  logic       w_alu_zero;
  logic [3:0] w_alu_f3;
  logic       w_d_regwe, w_d_rs1sel, w_d_rs2sel, w_d_we;
  logic [1:0] w_d_regsel, w_d_pcsel;
  logic [2:0] w_d_immsel;
  logic [3:0] w_d_alu;
  logic       w_illegal, w_ecall, w_ebreak;
  logic       w_exec, w_trap_now, w_retire;
  logic [1:0] w_cause;

  assign w_op       = Instr[6:0];
  assign w_f3       = Instr[14:12];
  assign w_f7       = Instr[31:25];
  assign w_alu_zero = (ALUResults == 32'd0);

  always_comb begin
    w_alu_f3 = ALU_ADD;
    case (w_f3)
      3'b001:  w_alu_f3 = ALU_SLL;
      3'b010:  w_alu_f3 = ALU_SLT;
      3'b011:  w_alu_f3 = ALU_SLTU;
      3'b100:  w_alu_f3 = ALU_XOR;
      3'b101:  w_alu_f3 = ALU_SRL;
      3'b110:  w_alu_f3 = ALU_OR;
      3'b111:  w_alu_f3 = ALU_AND;
      default: w_alu_f3 = ALU_ADD;
    endcase
  end

  // Raw decode, independent of run state; the output stage decides whether it is applied.
  always_comb begin
    w_d_regwe  = 1'b0;
    w_d_rs1sel = 1'b0;
    w_d_rs2sel = 1'b0;
    w_d_we     = 1'b0;
    w_d_regsel = WB_ALU;
    w_d_pcsel  = PC_PLUS4;
    w_d_immsel = IMM_I;
    w_d_alu    = ALU_ADD;
    w_illegal  = 1'b0;
    w_ecall    = 1'b0;
    w_ebreak   = 1'b0;
    case (w_op)
      OP_LUI: begin
        w_d_regwe  = 1'b1;
        w_d_rs2sel = 1'b1;
        w_d_immsel = IMM_U;
        w_d_alu    = ALU_PASSB;
      end
      OP_AUIPC: begin
        w_d_regwe  = 1'b1;
        w_d_rs1sel = 1'b1;
        w_d_rs2sel = 1'b1;
        w_d_immsel = IMM_U;
      end
      OP_JAL: begin
        w_d_regwe  = 1'b1;
        w_d_immsel = IMM_J;
        w_d_pcsel  = PC_IMM;
        w_d_regsel = WB_PC4;
      end
      OP_JALR: begin
        w_illegal  = (w_f3 != 3'b000);
        w_d_regwe  = 1'b1;
        w_d_rs2sel = 1'b1;
        w_d_pcsel  = PC_ALU;
        w_d_regsel = WB_PC4;
      end
      OP_BRANCH: begin
        w_d_immsel = IMM_B;
        case (w_f3)
          3'b000: begin w_d_alu = ALU_SUB;  w_d_pcsel = w_alu_zero     ? PC_IMM : PC_PLUS4; end
          3'b001: begin w_d_alu = ALU_SUB;  w_d_pcsel = !w_alu_zero    ? PC_IMM : PC_PLUS4; end
          3'b100: begin w_d_alu = ALU_SLT;  w_d_pcsel = ALUResults[0]  ? PC_IMM : PC_PLUS4; end
          3'b101: begin w_d_alu = ALU_SLT;  w_d_pcsel = !ALUResults[0] ? PC_IMM : PC_PLUS4; end
          3'b110: begin w_d_alu = ALU_SLTU; w_d_pcsel = ALUResults[0]  ? PC_IMM : PC_PLUS4; end
          3'b111: begin w_d_alu = ALU_SLTU; w_d_pcsel = !ALUResults[0] ? PC_IMM : PC_PLUS4; end
          default: w_illegal = 1'b1;
        endcase
      end
      OP_LOAD: begin
        w_illegal  = (w_f3 == 3'b011) || (w_f3 == 3'b110) || (w_f3 == 3'b111);
        w_d_regwe  = 1'b1;
        w_d_rs2sel = 1'b1;
        w_d_regsel = WB_DMEM;
      end
      OP_STORE: begin
        w_illegal  = (w_f3 > 3'b010);
        w_d_we     = 1'b1;
        w_d_rs2sel = 1'b1;
        w_d_immsel = IMM_S;
      end
      OP_IMM: begin
        w_d_regwe  = 1'b1;
        w_d_rs2sel = 1'b1;
        w_d_alu    = w_alu_f3;
        if (w_f3 == 3'b001) begin
          w_illegal = (w_f7 != 7'b0000000);
        end else if (w_f3 == 3'b101) begin
          if (w_f7 == 7'b0100000) w_d_alu = ALU_SRA;
          else w_illegal = (w_f7 != 7'b0000000);
        end
      end
      OP_REG: begin
        w_d_regwe = 1'b1;
        w_d_alu   = w_alu_f3;
        if (w_f7 == 7'b0100000) begin
          if (w_f3 == 3'b000)      w_d_alu = ALU_SUB;
          else if (w_f3 == 3'b101) w_d_alu = ALU_SRA;
          else                     w_illegal = 1'b1;
        end else begin
          w_illegal = (w_f7 != 7'b0000000);
        end
      end
      OP_FENCE: w_illegal = (w_f3 != 3'b000);
      OP_SYSTEM: begin
        w_ecall   = (Instr == 32'h0000_0073);
        w_ebreak  = (Instr == 32'h0010_0073);
        w_illegal = !(w_ecall || w_ebreak);
      end
      default: w_illegal = 1'b1;
    endcase
  end

  assign w_exec     = (r_state == ST_RUN) || (r_state == ST_STEP);
  assign w_trap_now = w_exec && (w_illegal || w_ecall || w_ebreak);
  assign w_retire   = w_exec && !w_trap_now;
  assign w_cause    = w_ecall ? 2'b10 : (w_ebreak ? 2'b11 : 2'b01);

  // Reset forces the safe bus combinationally so nothing leaks while reset is held.
  always_comb begin
    regWE      = 1'b0;
    rs1sel     = 1'b0;
    rs2sel     = 1'b0;
    regsel     = WB_ALU;
    PCsel      = PC_HOLD;
    ImmSel     = IMM_I;
    ALUControl = ALU_ADD;
    we         = 1'b0;
    mode       = 3'b000;
    if (reset && w_retire) begin
      regWE      = w_d_regwe;
      rs1sel     = w_d_rs1sel;
      rs2sel     = w_d_rs2sel;
      regsel     = w_d_regsel;
      PCsel      = w_d_pcsel;
      ImmSel     = w_d_immsel;
      ALUControl = w_d_alu;
      we         = w_d_we;
      mode       = w_f3;
    end else if (reset && (r_state == ST_SKIP)) begin
      PCsel = PC_PLUS4;
    end
  end

  assign halted     = (r_state == ST_HALT) || (r_state == ST_TRAP);
  assign trap       = (r_state == ST_TRAP);
  assign trap_cause = r_trap_cause;

  // dbg_*_req are level requests sampled on every rising edge with no acknowledge;
  // the requester watches halted/trap and deasserts once the state has moved.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_BOOT;
      r_trap_cause  <= 2'b00;
      r_skip_to_run <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_trap_now) begin
            r_state      <= ST_TRAP;
            r_trap_cause <= w_cause;
          end else if (dbg_halt_req) begin
            r_state <= ST_HALT;
          end
        end
        ST_HALT: begin
          if (dbg_step_req)     r_state <= ST_STEP;
          else if (dbg_run_req) r_state <= ST_RUN;
        end
        ST_STEP: begin
          if (w_trap_now) begin
            r_state      <= ST_TRAP;
            r_trap_cause <= w_cause;
          end else begin
            r_state <= ST_HALT;
          end
        end
        ST_TRAP: begin
          if (dbg_run_req || dbg_step_req) begin
            r_state       <= ST_SKIP;
            r_trap_cause  <= 2'b00;
            r_skip_to_run <= !dbg_step_req;
          end
        end
        ST_SKIP: r_state <= r_skip_to_run ? ST_RUN : ST_HALT;
        default: r_state <= ST_BOOT;
      endcase
    end
  end

`ifdef CORE_SEQ_INSTRET_EN
  logic [INSTRET_W-1:0] r_instret;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_instret <= '0;
    else if (w_retire) r_instret <= r_instret + INSTRET_W'(1);
  end

  assign instret = r_instret;
`else
  assign instret = '0;
`endif

endmodule

// File: tb/tb_core_sequencer.sv
// Bench for core_sequencer: decode vector table, hand-written debug/trap/reset sequences,
// and randomized instruction/request streams checked against a behavioural model.

module tb_core_sequencer;

  localparam int W = 22;
`ifdef CORE_SEQ_INSTRET_EN
  localparam int INC = 1;
`else
  localparam int INC = 0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr, alu_res;
  logic        halt_req, run_req, step_req;

  logic        regwe, rs1sel, rs2sel, we, halted, trap;
  logic [1:0]  regsel, pcsel, tcause;
  logic [2:0]  immsel, mode;
  logic [3:0]  aluctl;
  logic [31:0] instret;

  logic        bh_regwe, bh_rs1sel, bh_rs2sel, bh_we, bh_halted, bh_trap;
  logic [1:0]  bh_regsel, bh_pcsel, bh_tcause;
  logic [2:0]  bh_immsel, bh_mode;
  logic [3:0]  bh_aluctl;
  logic [31:0] bh_instret;

  always #5 clk = ~clk;

  core_sequencer #(.BOOT_HALTED(0), .INSTRET_W(32)) u_dut (
    .clk(clk), .reset(reset), .Instr(instr), .ALUResults(alu_res),
    .dbg_halt_req(halt_req), .dbg_run_req(run_req), .dbg_step_req(step_req),
    .regWE(regwe), .rs1sel(rs1sel), .rs2sel(rs2sel), .regsel(regsel), .PCsel(pcsel),
    .ImmSel(immsel), .ALUControl(aluctl), .we(we), .mode(mode), .halted(halted),
    .trap(trap), .trap_cause(tcause), .instret(instret)
  );

  core_sequencer #(.BOOT_HALTED(1), .INSTRET_W(32)) u_dut_bh (
    .clk(clk), .reset(reset), .Instr(instr), .ALUResults(alu_res),
    .dbg_halt_req(1'b0), .dbg_run_req(1'b0), .dbg_step_req(1'b0),
    .regWE(bh_regwe), .rs1sel(bh_rs1sel), .rs2sel(bh_rs2sel), .regsel(bh_regsel), .PCsel(bh_pcsel),
    .ImmSel(bh_immsel), .ALUControl(bh_aluctl), .we(bh_we), .mode(bh_mode), .halted(bh_halted),
    .trap(bh_trap), .trap_cause(bh_tcause), .instret(bh_instret)
  );

  logic [W-1:0] act;
  assign act = {regwe, rs1sel, rs2sel, regsel, pcsel, immsel, aluctl, we, mode, halted, trap, tcause};

  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];

  // ---------------- behavioural reference model ----------------
  localparam int M_RUN = 0, M_HALT = 1, M_STEP = 2, M_TRAP = 3, M_SKIP = 4;
  int          m_state;
  logic [1:0]  m_cause;
  bit          m_skip_run;
  logic [31:0] m_instret;

  typedef enum int {K_LUI, K_AUIPC, K_JAL, K_JALR, K_BR, K_LOAD, K_STORE,
                    K_ALUI, K_ALUR, K_FENCE, K_ECALL, K_EBREAK, K_ILL} kind_t;

  function automatic logic [W-1:0] pk(int rwe, int r1, int r2, int rsel, int pcs, int imm,
                                      int alu, int w, int md, int h, int t, int tc);
    return {rwe[0], r1[0], r2[0], rsel[1:0], pcs[1:0], imm[2:0], alu[3:0], w[0], md[2:0],
            h[0], t[0], tc[1:0]};
  endfunction

  function automatic kind_t classify(input logic [31:0] i);
    logic [6:0] op = i[6:0];
    int f3 = int'(i[14:12]);
    int f7 = int'(i[31:25]);
    if (op == 7'h37) return K_LUI;
    if (op == 7'h17) return K_AUIPC;
    if (op == 7'h6f) return K_JAL;
    if (op == 7'h67) return (f3 == 0) ? K_JALR : K_ILL;
    if (op == 7'h63) return (f3 == 2 || f3 == 3) ? K_ILL : K_BR;
    if (op == 7'h03) return (f3 inside {0, 1, 2, 4, 5}) ? K_LOAD : K_ILL;
    if (op == 7'h23) return (f3 <= 2) ? K_STORE : K_ILL;
    if (op == 7'h13) begin
      if (f3 == 1 && f7 != 0) return K_ILL;
      if (f3 == 5 && !(f7 == 0 || f7 == 32)) return K_ILL;
      return K_ALUI;
    end
    if (op == 7'h33) begin
      if (f7 == 0) return K_ALUR;
      if (f7 == 32 && (f3 == 0 || f3 == 5)) return K_ALUR;
      return K_ILL;
    end
    if (op == 7'h0f) return (f3 == 0) ? K_FENCE : K_ILL;
    if (i == 32'h0000_0073) return K_ECALL;
    if (i == 32'h0010_0073) return K_EBREAK;
    return K_ILL;
  endfunction

  function automatic bit is_trap_kind(input kind_t k);
    return (k == K_ECALL) || (k == K_EBREAK) || (k == K_ILL);
  endfunction

  function automatic logic [W-1:0] model_out(input logic [31:0] i, input logic [31:0] a);
    int alu_tab[8] = '{0, 2, 3, 4, 5, 6, 8, 9};
    kind_t k = classify(i);
    int f3 = int'(i[14:12]);
    int h = (m_state == M_HALT || m_state == M_TRAP) ? 1 : 0;
    int t = (m_state == M_TRAP) ? 1 : 0;
    int tc = int'(m_cause);
    bit exec = (m_state == M_RUN || m_state == M_STEP);
    int alu, taken;
    if (!exec || is_trap_kind(k))
      return pk(0, 0, 0, 0, (m_state == M_SKIP) ? 0 : 3, 0, 0, 0, 0, h, t, tc);
    case (k)
      K_LUI:   return pk(1, 0, 1, 0, 0, 3, 10, 0, f3, h, t, tc);
      K_AUIPC: return pk(1, 1, 1, 0, 0, 3, 0, 0, f3, h, t, tc);
      K_JAL:   return pk(1, 0, 0, 2, 1, 4, 0, 0, f3, h, t, tc);
      K_JALR:  return pk(1, 0, 1, 2, 2, 0, 0, 0, f3, h, t, tc);
      K_BR: begin
        alu = (f3 < 4) ? 1 : ((f3 < 6) ? 3 : 4);
        case (f3)
          0: taken = (a == 0) ? 1 : 0;
          1: taken = (a != 0) ? 1 : 0;
          4, 6: taken = a[0] ? 1 : 0;
          default: taken = a[0] ? 0 : 1;
        endcase
        return pk(0, 0, 0, 0, taken, 2, alu, 0, f3, h, t, tc);
      end
      K_LOAD:  return pk(1, 0, 1, 1, 0, 0, 0, 0, f3, h, t, tc);
      K_STORE: return pk(0, 0, 1, 0, 0, 1, 0, 1, f3, h, t, tc);
      K_ALUI: begin
        alu = (f3 == 5 && i[30]) ? 7 : alu_tab[f3];
        return pk(1, 0, 1, 0, 0, 0, alu, 0, f3, h, t, tc);
      end
      K_ALUR: begin
        alu = i[30] ? ((f3 == 0) ? 1 : 7) : alu_tab[f3];
        return pk(1, 0, 0, 0, 0, 0, alu, 0, f3, h, t, tc);
      end
      default: return pk(0, 0, 0, 0, 0, 0, 0, 0, f3, h, t, tc);
    endcase
  endfunction

  task automatic model_step(input logic [31:0] i, input logic h, input logic r, input logic s);
    kind_t k = classify(i);
    logic [1:0] cause = (k == K_ECALL) ? 2'b10 : ((k == K_EBREAK) ? 2'b11 : 2'b01);
    case (m_state)
      M_RUN, M_STEP: begin
        if (is_trap_kind(k)) begin
          m_state = M_TRAP;
          m_cause = cause;
        end else begin
          m_instret = m_instret + INC;
          if (m_state == M_STEP) m_state = M_HALT;
          else if (h) m_state = M_HALT;
        end
      end
      M_HALT: if (s) m_state = M_STEP; else if (r) m_state = M_RUN;
      M_TRAP: if (r || s) begin m_state = M_SKIP; m_skip_run = !s; m_cause = 2'b00; end
      default: m_state = m_skip_run ? M_RUN : M_HALT;
    endcase
  endtask

  task automatic model_reset();
    m_state = M_RUN;
    m_cause = 2'b00;
    m_skip_run = 1'b0;
    m_instret = 32'd0;
    exp_q.delete();
  endtask

  // ---------------- checking and driver tasks ----------------
  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
    end
  endtask

  logic [31:0] cur_i;
  logic        cur_h, cur_r, cur_s;

  task automatic drive(input logic [31:0] i, input logic [31:0] a,
                       input logic h, input logic r, input logic s);
    logic [W-1:0] e;
    instr = i; alu_res = a; halt_req = h; run_req = r; step_req = s;
    cur_i = i; cur_h = h; cur_r = r; cur_s = s;
    exp_q.push_back(model_out(i, a));
    @(negedge clk);
    e = exp_q.pop_front();
    check("ctrl_bus", 32'(act), 32'(e));
    check("instret", instret, m_instret);
  endtask

  task automatic advance();
    @(posedge clk);
    model_step(cur_i, cur_h, cur_r, cur_s);
    #1;
  endtask

  typedef struct {
    logic [31:0]  instr;
    logic [31:0]  alu;
    logic [W-1:0] exp;
    string        name;
  } vec_t;

  localparam logic [31:0] I_ADDI   = 32'h0050_0093;
  localparam logic [31:0] I_SW     = 32'h0020_2223;
  localparam logic [31:0] I_EBREAK = 32'h0010_0073;
  localparam logic [31:0] I_ECALL  = 32'h0000_0073;
  localparam int NV = 16;

  vec_t        tab[NV];
  logic [31:0] pool[NV];
  logic [31:0] before_ir, rnd, ri, ra;
  int          sel;

  initial begin
    tab[0]  = '{32'h0050_0093, 32'd0, pk(1,0,1,0,0,0,0,0,0,0,0,0),  "addi"};
    tab[1]  = '{32'h0000_0463, 32'd0, pk(0,0,0,0,1,2,1,0,0,0,0,0),  "beq_taken"};
    tab[2]  = '{32'h0000_0463, 32'd1, pk(0,0,0,0,0,2,1,0,0,0,0,0),  "beq_not"};
    tab[3]  = '{32'h0000_1463, 32'd5, pk(0,0,0,0,1,2,1,0,1,0,0,0),  "bne_taken"};
    tab[4]  = '{32'h0000_4463, 32'd1, pk(0,0,0,0,1,2,3,0,4,0,0,0),  "blt_taken"};
    tab[5]  = '{32'h0000_7463, 32'd1, pk(0,0,0,0,0,2,4,0,7,0,0,0),  "bgeu_not"};
    tab[6]  = '{32'h0001_0137, 32'd0, pk(1,0,1,0,0,3,10,0,0,0,0,0), "lui"};
    tab[7]  = '{32'h0000_1197, 32'd0, pk(1,1,1,0,0,3,0,0,1,0,0,0),  "auipc"};
    tab[8]  = '{32'h0100_00ef, 32'd0, pk(1,0,0,2,1,4,0,0,0,0,0,0),  "jal"};
    tab[9]  = '{32'h0000_8067, 32'd0, pk(1,0,1,2,2,0,0,0,0,0,0,0),  "jalr"};
    tab[10] = '{32'h0020_2223, 32'd0, pk(0,0,1,0,0,1,0,1,2,0,0,0),  "sw"};
    tab[11] = '{32'h0080_2283, 32'd0, pk(1,0,1,1,0,0,0,0,2,0,0,0),  "lw"};
    tab[12] = '{32'h0000_000f, 32'd0, pk(0,0,0,0,0,0,0,0,0,0,0,0),  "fence"};
    tab[13] = '{32'h4020_81b3, 32'd0, pk(1,0,0,0,0,0,1,0,0,0,0,0),  "sub"};
    tab[14] = '{32'h4030_d213, 32'd0, pk(1,0,1,0,0,0,7,0,5,0,0,0),  "srai"};
    tab[15] = '{32'h0020_b2b3, 32'd0, pk(1,0,0,0,0,0,4,0,3,0,0,0),  "sltu"};
    for (int k = 0; k < NV; k++) pool[k] = tab[k].instr;

    // clock/reset
    reset = 1'b0; instr = I_ADDI; alu_res = 32'd0;
    halt_req = 1'b0; run_req = 1'b0; step_req = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_safe_bus", 32'(act), 32'(pk(0,0,0,0,3,0,0,0,0,0,0,0)));
    check("rst_instret", instret, 32'd0);
    check("bh_rst_halted", 32'(bh_halted), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("bh_boot_halted", 32'(bh_halted), 32'd1);
    check("bh_boot_pcsel", 32'(bh_pcsel), 32'd3);
    check("bh_boot_regwe", 32'(bh_regwe), 32'd0);
    @(posedge clk);
    #1;

    // decode vector table, all in RUN
    for (int k = 0; k < NV; k++) begin
      drive(tab[k].instr, tab[k].alu, 1'b0, 1'b0, 1'b0);
      check(tab[k].name, 32'(act), 32'(tab[k].exp));
      advance();
    end

    // halt pulse: sampled instruction still retires, then HALT
    before_ir = m_instret;
    drive(I_ADDI, 32'd0, 1'b1, 1'b0, 1'b0);
    check("halt_cycle_regwe", 32'(regwe), 32'd1);
    advance();
    drive(I_ADDI, 32'd0, 1'b0, 1'b0, 1'b0);
    check("halt_halted", 32'(halted), 32'd1);
    check("halt_pcsel", 32'(pcsel), 32'd3);
    check("halt_regwe", 32'(regwe), 32'd0);
    check("halt_we", 32'(we), 32'd0);
    check("halt_retired", instret, before_ir + INC);
    advance();

    // single step of a store
    drive(I_SW, 32'd0, 1'b0, 1'b0, 1'b1);
    check("step_req_we", 32'(we), 32'd0);
    advance();
    drive(I_SW, 32'd0, 1'b0, 1'b0, 1'b0);
    check("step_we", 32'(we), 32'd1);
    check("step_mode", 32'(mode), 32'd2);
    check("step_immsel", 32'(immsel), 32'd1);
    advance();
    drive(I_SW, 32'd0, 1'b0, 1'b0, 1'b0);
    check("step_back_halted", 32'(halted), 32'd1);
    check("step_back_we", 32'(we), 32'd0);
    advance();

    // EBREAK trap, exit via run
    drive(I_ADDI, 32'd0, 1'b0, 1'b1, 1'b0);
    advance();
    drive(I_EBREAK, 32'd0, 1'b0, 1'b0, 1'b0);
    check("trapcyc_regwe", 32'(regwe), 32'd0);
    check("trapcyc_pcsel", 32'(pcsel), 32'd3);
    advance();
    drive(I_ADDI, 32'd0, 1'b0, 1'b1, 1'b0);
    check("trap_flag", 32'(trap), 32'd1);
    check("trap_cause_ebreak", 32'(tcause), 32'd3);
    advance();
    drive(I_ADDI, 32'd0, 1'b0, 1'b0, 1'b0);
    check("skip_pcsel", 32'(pcsel), 32'd0);
    check("skip_regwe", 32'(regwe), 32'd0);
    check("skip_cause_clr", 32'(tcause), 32'd0);
    advance();
    drive(I_ADDI, 32'd0, 1'b0, 1'b0, 1'b0);
    check("skip_to_run", 32'(regwe), 32'd1);
    advance();

    // ECALL trap, exit via step lands in HALT
    drive(I_ECALL, 32'd0, 1'b0, 1'b0, 1'b0);
    advance();
    drive(I_ADDI, 32'd0, 1'b0, 1'b0, 1'b1);
    check("trap_cause_ecall", 32'(tcause), 32'd2);
    advance();
    drive(I_ADDI, 32'd0, 1'b0, 1'b0, 1'b0);
    advance();
    drive(I_ADDI, 32'd0, 1'b0, 1'b1, 1'b0);
    check("skip_to_halt", 32'(halted), 32'd1);
    advance();

    // asynchronous reset between edges while running
    drive(I_ADDI, 32'd0, 1'b0, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_bus", 32'(act), 32'(pk(0,0,0,0,3,0,0,0,0,0,0,0)));
    check("async_rst_instret", instret, 32'd0);
    check("async_rst_cause", 32'(tcause), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();

    // randomized instruction / request stream
    for (int n = 0; n < 1500; n++) begin
      sel = $urandom_range(0, 99);
      ri = pool[$urandom_range(0, NV - 1)];
      rnd = $urandom;
      if (sel < 55) begin
        ri[11:7] = rnd[4:0]; ri[19:15] = rnd[9:5]; ri[24:20] = rnd[14:10];
      end else if (sel < 70) begin
        ri = rnd;
      end else if (sel < 85) begin
        ri[14:12] = rnd[2:0]; ri[30] = rnd[3]; ri[29] = rnd[4];
      end else if (sel < 92) begin
        ri = rnd[0] ? I_EBREAK : I_ECALL;
      end else begin
        ri = {rnd[31:7], 7'h73};
      end
      case ($urandom_range(0, 2))
        0: ra = 32'd0;
        1: ra = 32'd1;
        default: ra = $urandom;
      endcase
      drive(ri, ra, ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 20),
            ($urandom_range(0, 99) < 15));
      advance();
    end

    check("bh_still_halted", 32'(bh_halted), 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/core_sequencer.md
Name: core_sequencer

Overview:
- Control unit and run-state sequencer for the single-cycle RV32I datapath.
- Decodes `Instr` into the datapath control bus: `regWE`, `rs1sel`, `rs2sel`, `regsel`, `PCsel`, `ImmSel`, `ALUControl`, dmem `we` and dmem `mode`.
- Gates execution through a run/halt/step/trap FSM driven by a debug handshake.
- Sits beside the datapath, imem and dmem; fully replaces the hand-driven control stimulus.

Parameters:
- BOOT_HALTED, 0, 1 = leave reset in HALT; 0 = leave reset in RUN.
- INSTRET_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- Instr  in  32  current instruction from imem.
- ALUResults  in  32  datapath ALU output; used for branch resolution.
- dbg_halt_req  in  1  level request: stop after the current instruction.
- dbg_run_req  in  1  level request: resume free-running.
- dbg_step_req  in  1  level request: execute exactly one instruction.
- regWE  out  1  register-file write enable.
- rs1sel  out  1  ALU A source: 0 = rs1, 1 = PC.
- rs2sel  out  1  ALU B source: 0 = rs2, 1 = immediate.
- regsel  out  2  writeback source: 00 = ALU, 01 = dmem, 10 = PC+4.
- PCsel  out  2  next PC: 00 = PC+4, 01 = PC+imm, 10 = ALU (JALR), 11 = hold.
- ImmSel  out  3  immediate format: 000 = I, 001 = S, 010 = B, 011 = U, 100 = J.
- ALUControl  out  4  ALU op encoding:
  - 0000 ADD, 0001 SUB, 0010 SLL, 0011 SLT, 0100 SLTU, 0101 XOR
  - 0110 SRL, 0111 SRA, 1000 OR, 1001 AND, 1010 PASSB
- we  out  1  dmem write enable.
- mode  out  3  dmem access size/sign; equals funct3.
- halted  out  1  high in the HALT and TRAP states.
- trap  out  1  high in the TRAP state.
- trap_cause  out  2  00 none, 01 illegal, 10 ECALL, 11 EBREAK.
- instret  out  INSTRET_W  retired-instruction count (optional feature).

Behaviour:
- States: RUN, HALT, STEP, TRAP, SKIP. State register only; decode is combinational from `Instr` and gated by state.
- Reset (reset = 0, asynchronous):
  - State enters HALT if BOOT_HALTED = 1, else RUN.
  - `trap_cause` = 00, `instret` = 0.
  - While reset is asserted, all outputs are at their safe values: `regWE` = 0, `we` = 0, `PCsel` = 11, other controls 0.
- Execute cycle (RUN or STEP, legal instruction):
  - Full decode is driven.
  - The PC, regfile and dmem update on the next rising edge. Latency is 1 cycle per instruction.
- Branch resolution:
  - BEQ/BNE: `ALUControl` = SUB; taken iff `ALUResults` == 0 (BEQ) or != 0 (BNE).
  - BLT/BGE: SLT, taken on `ALUResults[0]` = 1 / 0.
  - BLTU/BGEU: SLTU, same rule on `ALUResults[0]`.
  - Taken: `PCsel` = 01. Not taken: `PCsel` = 00.
- JAL: `PCsel` = 01, `regsel` = 10. JALR: `PCsel` = 10, `regsel` = 10.
- LUI: PASSB with `ImmSel` = U. AUIPC: `rs1sel` = 1, ADD.
- FENCE decodes as a NOP with PC+4.
- Writes to x0 are the regfile's concern; the sequencer still drives `regWE` = 1.
- Non-executing cycles (HALT, TRAP): `regWE` = 0, `we` = 0, `PCsel` = 11.
- Trap cycle: ECALL, EBREAK or an illegal opcode/funct in RUN or STEP:
  - Writes are suppressed and `PCsel` = 11 that cycle.
  - Next state is TRAP; `trap_cause` latches.
  - The instruction does not retire.
- Transitions:
  - RUN: `dbg_halt_req` -> HALT. The instruction in the sampling cycle still executes and retires.
  - HALT: `dbg_step_req` -> STEP; otherwise `dbg_run_req` -> RUN. Step wins if both are asserted.
  - STEP: always -> HALT after one execute cycle, unless it traps (-> TRAP).
  - TRAP: `dbg_run_req` or `dbg_step_req` -> SKIP. `trap_cause` clears on exit.
  - SKIP: one cycle with `PCsel` = 00 and writes off (steps past the trapping instruction) -> RUN if it was entered via run, HALT if via step.
- Priority in RUN: trap > `dbg_halt_req`.
- Requests are level-sampled every edge. A request held high across the return to HALT produces another step (caller deasserts).

Optional Feature:
- Macro: CORE_SEQ_INSTRET_EN.
- Defined:
  - `instret` increments by 1 on each retiring execute cycle.
  - Trap and SKIP cycles do not count.
  - Wraps from 2^INSTRET_W-1 to 0.
- Undefined: the counter is absent and `instret` is tied to 0.

Test Plan:
- BOOT_HALTED = 0; release reset; `Instr` = 0x00500093 (ADDI x1,x0,5) -> same cycle `regWE` = 1, `rs2sel` = 1, `ImmSel` = 000, `ALUControl` = 0000, `regsel` = 00, `PCsel` = 00.
- `Instr` = BEQ; `ALUResults` = 0 -> `PCsel` = 01, `ImmSel` = 010, `regWE` = 0. With `ALUResults` = 1 -> `PCsel` = 00.
- RUN; pulse `dbg_halt_req` for 1 cycle -> that instruction retires (`instret` +1); then `halted` = 1, `PCsel` = 11, `regWE` = 0, `we` = 0.
- HALT; `dbg_step_req` for 1 cycle with SW -> exactly one cycle of `we` = 1, `mode` = 010, `ImmSel` = 001; then back in HALT.
- `Instr` = 0x00100073 (EBREAK) -> `trap` = 1, `trap_cause` = 11, no writes; `dbg_run_req` -> one SKIP cycle (`PCsel` = 00), then RUN, `trap_cause` = 00.
- Assert reset = 0 mid-RUN between clock edges -> outputs go immediately to safe values, `instret` = 0, `trap_cause` = 00.
